// File: rtl/btn_sw_debounce_pkg.sv
// Shared sizing constants for the button/switch conditioning stage.
// DB_CYCLES_SIM shortens the debounce window so simulation stays fast.
package btn_sw_debounce_pkg;

  localparam int N_BTN_DEF     = 5;
  localparam int N_SW_DEF      = 16;
  localparam int DB_CYCLES_DEF = 100000;
  localparam int DB_CYCLES_SIM = 4;

endpackage

// File: rtl/btn_sw_debounce_ch.sv
// One input channel: 2-flop synchroniser, consecutive-cycle counter and
// accepted (stable) level. A level is accepted after DB_CYCLES unbroken cycles.
module debounce_ch
  import btn_sw_debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o
);

  localparam int              CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can leave it
    // unassigned and infer a latch.
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // this is what makes sync1 -> sync2 a real two-stage chain.
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/btn_sw_debounce.sv
// Debounced buttons/switches feeding the MIO bus, plus registered press
// pulses and a sticky, CPU-clearable press-event register with summary IRQ.
module btn_sw_debounce
  import btn_sw_debounce_pkg::*;
#(
  parameter int N_BTN     = N_BTN_DEF,
  parameter int N_SW      = N_SW_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  input  logic [N_SW-1:0]  sw_i,
  output logic [N_BTN-1:0] btn_out,
  output logic [N_SW-1:0]  sw_out,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] evt_pending,
  input  logic             evt_clr_we,
  input  logic [N_BTN-1:0] evt_clr_mask,
  output logic             evt_irq
);

  localparam int N_CH = N_BTN + N_SW;

  logic [N_CH-1:0]  raw;
  logic [N_CH-1:0]  stable;

  logic [N_BTN-1:0] btn_prev_q,  btn_prev_d;
  logic [N_BTN-1:0] btn_press_q, btn_press_d;
  logic [N_BTN-1:0] evt_q,       evt_d;
  logic             irq_q,       irq_d;
  logic [N_BTN-1:0] clr_bits;

  // Buttons occupy the low channels, switches the high ones.
  assign raw = {sw_i, btn_i};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES (DB_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (raw[g]),
      .stable_o (stable[g])
    );
  end

  assign btn_out = stable[N_BTN-1:0];
  assign sw_out  = stable[N_CH-1:N_BTN];

  // Set beats clear: a press landing on a clearing write keeps its flag.
  always_comb begin
    btn_prev_d  = btn_out;
    btn_press_d = btn_out & ~btn_prev_q;
    clr_bits    = evt_clr_we ? evt_clr_mask : '0;
    evt_d       = (evt_q & ~clr_bits) | btn_press_q;
    irq_d       = |evt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q  <= '0;
      btn_press_q <= '0;
      evt_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      btn_prev_q  <= btn_prev_d;
      btn_press_q <= btn_press_d;
      evt_q       <= evt_d;
      irq_q       <= irq_d;
    end
  end

  assign btn_press   = btn_press_q;
  assign evt_pending = evt_q;
  assign evt_irq     = irq_q;

endmodule
